// File: rtl/portal_msg_deserializer_pkg.sv
// Shared types for the portal message deserializer.
//   portal_header_t         : header word layout {method id, total frame length in words}
//   deser_state_e           : deserializer frame-tracking states
//   MAX_WORDS_DEFAULT       : default maximum payload words per message
package portal_msg_deserializer_pkg;

  localparam int MAX_WORDS_DEFAULT = 8;

  // Header word: [31:16] method id, [15:0] frame length including the header itself.
  typedef struct packed {
    logic [15:0] method;
    logic [15:0] length;
  } portal_header_t;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    BODY    = 2'd1,
    DISCARD = 2'd2,
    EMIT    = 2'd3
  } deser_state_e;

endpackage

// File: rtl/portal_msg_deserializer.sv
// Portal request message deserializer.
// Consumes the 32-bit word stream from the AXI slave bridge user write port,
// reassembles header + payload frames into one wide method-call transaction,
// and drops zero-length or oversize frames without stalling the bridge.
// Ports:
//   CLK, nRST    : clock, asynchronous active-low reset
//   in__ENA      : word valid from bridge
//   in__data     : header or payload word
//   in__RDY      : block accepts a word this cycle
//   out__ENA     : assembled message valid (held until out__RDY)
//   out__method  : method id from header
//   out__length  : payload word count, 0..MAX_WORDS
//   out__data    : payload, word k at [32k+31:32k], unused words zero
//   out__RDY     : user accepts message
//   drop__ENA    : one-cycle pulse after a header is rejected
//   errCount     : rejected-header count, saturating at 0xFFFF
module portal_msg_deserializer
  import portal_msg_deserializer_pkg::*;
#(
  parameter int MAX_WORDS    = MAX_WORDS_DEFAULT,
  parameter int METHOD_WIDTH = 16
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             in__ENA,
  input  logic [31:0]                      in__data,
  output logic                             in__RDY,
  output logic                             out__ENA,
  output logic [METHOD_WIDTH-1:0]          out__method,
  output logic [$clog2(MAX_WORDS+1)-1:0]   out__length,
  output logic [32*MAX_WORDS-1:0]          out__data,
  input  logic                             out__RDY,
  output logic                             drop__ENA,
  output logic [15:0]                      errCount
);

  localparam int LEN_W = $clog2(MAX_WORDS + 1);
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  deser_state_e              state_q, state_d;
  logic [15:0]               remaining_q, remaining_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic [METHOD_WIDTH-1:0]   method_q, method_d;
  logic [LEN_W-1:0]          length_q, length_d;
  logic [32*MAX_WORDS-1:0]   data_q, data_d;
  logic                      drop_q, drop_d;
  logic [15:0]               err_q, err_d;
  logic                      rdy_q;

  portal_header_t            hdr;
  logic                      accept;

  assign hdr = in__data;

  // rdy_q keeps in__RDY low while reset is held and for the first edge after
  // release, without a combinational path from nRST to the output.
  assign in__RDY     = rdy_q && (state_q != EMIT);
  assign accept      = in__ENA && in__RDY;
  assign out__ENA    = (state_q == EMIT);
  assign out__method = method_q;
  assign out__length = length_q;
  assign out__data   = data_q;
  assign drop__ENA   = drop_q;
  assign errCount    = err_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    method_d    = method_q;
    length_d    = length_q;
    data_d      = data_q;
    drop_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      HDR: begin
        if (accept) begin
          if (hdr.length == 16'd1) begin
            method_d = METHOD_WIDTH'(hdr.method);
            length_d = '0;
            data_d   = '0;
            state_d  = EMIT;
          end else if ((hdr.length >= 16'd2) && (hdr.length <= 16'(MAX_WORDS + 1))) begin
            method_d    = METHOD_WIDTH'(hdr.method);
            length_d    = LEN_W'(hdr.length - 16'd1);
            data_d      = '0;
            remaining_d = hdr.length - 16'd1;
            index_d     = '0;
            state_d     = BODY;
          end else begin
            drop_d = 1'b1;
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            // A zero-length header has no body to skip; the next word is a header.
            if (hdr.length != 16'd0) begin
              remaining_d = hdr.length - 16'd1;
              state_d     = DISCARD;
            end
          end
        end
      end

      BODY: begin
        if (accept) begin
          for (int k = 0; k < MAX_WORDS; k++) begin
            if (index_q == IDX_W'(k)) begin
              data_d[32*k +: 32] = in__data;
            end
          end
          index_d     = index_q + IDX_W'(1);
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = EMIT;
          end
        end
      end

      DISCARD: begin
        if (accept) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = HDR;
          end
        end
      end

      EMIT: begin
        if (out__RDY) begin
          state_d = HDR;
        end
      end

      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= HDR;
      remaining_q <= '0;
      index_q     <= '0;
      method_q    <= '0;
      length_q    <= '0;
      data_q      <= '0;
      drop_q      <= 1'b0;
      err_q       <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      method_q    <= method_d;
      length_q    <= length_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      rdy_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_portal_msg_deserializer.sv
// Directed bench for portal_msg_deserializer (MAX_WORDS=8).
module tb_portal_msg_deserializer;

  logic         CLK;
  logic         nRST;
  logic         in_ena;
  logic [31:0]  in_data;
  logic         in_rdy;
  logic         out_ena;
  logic [15:0]  out_method;
  logic [3:0]   out_length;
  logic [255:0] out_data;
  logic         out_rdy;
  logic         drop_ena;
  logic [15:0]  err_count;

  int tests;
  int fails;
  int hs_cnt;
  int drop_cnt;

  portal_msg_deserializer #(.MAX_WORDS(8), .METHOD_WIDTH(16)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .in__ENA     (in_ena),
    .in__data    (in_data),
    .in__RDY     (in_rdy),
    .out__ENA    (out_ena),
    .out__method (out_method),
    .out__length (out_length),
    .out__data   (out_data),
    .out__RDY    (out_rdy),
    .drop__ENA   (drop_ena),
    .errCount    (err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event counters: values sampled at the edge are the pre-edge values.
  always @(posedge CLK) begin
    if (out_ena && out_rdy) hs_cnt <= hs_cnt + 1;
    if (drop_ena) drop_cnt <= drop_cnt + 1;
  end

  // Drive one word and return #1 after the edge that accepts it.
  task automatic put_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge CLK);
    in_ena  = 1'b1;
    in_data = w;
    while (!in_rdy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (!in_rdy) begin
      fails++;
      $display("FAIL put_word_timeout: in__RDY=%0b, required 1 within 100 cycles", in_rdy);
    end
    @(posedge CLK);
    #1;
    in_ena = 1'b0;
  endtask

  task automatic test_reset();
    nRST    = 1'b0;
    in_ena  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if (in_rdy !== 1'b0) begin fails++; $display("FAIL reset_in_rdy: got %0b, required 0", in_rdy); end
    tests++;
    if (out_ena !== 1'b0 || drop_ena !== 1'b0) begin
      fails++; $display("FAIL reset_enables: out__ENA=%0b drop__ENA=%0b, required 0 0", out_ena, drop_ena);
    end
    tests++;
    if (out_method !== 16'd0 || out_length !== 4'd0 || out_data !== 256'd0 || err_count !== 16'd0) begin
      fails++; $display("FAIL reset_values: method=%h length=%0d data=%h err=%0d, required all 0",
                        out_method, out_length, out_data, err_count);
    end
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    tests++;
    if (in_rdy !== 1'b1) begin fails++; $display("FAIL reset_release_rdy: got %0b, required 1", in_rdy); end
  endtask

  task automatic test_basic();
    int h0;
    logic [255:0] exp;
    exp = '0;
    exp[63:0] = 64'hBBBB0002_AAAA0001;
    out_rdy = 1'b1;
    h0 = hs_cnt;
    put_word(32'h0003_0003);
    put_word(32'hAAAA_0001);
    tests++;
    if (out_ena !== 1'b0) begin fails++; $display("FAIL basic_early_ena: got %0b, required 0", out_ena); end
    put_word(32'hBBBB_0002);
    tests++;
    if (out_ena !== 1'b1) begin fails++; $display("FAIL basic_latency: out__ENA=%0b, required 1", out_ena); end
    tests++;
    if (out_method !== 16'd3 || out_length !== 4'd2 || out_data !== exp) begin
      fails++; $display("FAIL basic_msg: method=%0d length=%0d data=%h, required 3 2 %h",
                        out_method, out_length, out_data, exp);
    end
    @(posedge CLK);
    #1;
    tests++;
    if (out_ena !== 1'b0 || hs_cnt !== h0 + 1) begin
      fails++; $display("FAIL basic_handshake: out__ENA=%0b count=%0d, required 0 %0d", out_ena, hs_cnt, h0 + 1);
    end
  endtask

  task automatic test_header_only();
    out_rdy = 1'b1;
    put_word(32'h0007_0001);
    tests++;
    if (out_ena !== 1'b1 || out_method !== 16'd7 || out_length !== 4'd0 || out_data !== 256'd0) begin
      fails++; $display("FAIL hdr_only_msg: ena=%0b method=%0d length=%0d data=%h, required 1 7 0 0",
                        out_ena, out_method, out_length, out_data);
    end
    @(posedge CLK);
    #1;
    tests++;
    if (in_rdy !== 1'b1 || out_ena !== 1'b0) begin
      fails++; $display("FAIL hdr_only_next_rdy: in__RDY=%0b out__ENA=%0b, required 1 0", in_rdy, out_ena);
    end
  endtask

  task automatic test_oversize();
    int h0;
    int d0;
    out_rdy = 1'b1;
    h0 = hs_cnt;
    d0 = drop_cnt;
    put_word(32'h0001_000B);
    tests++;
    if (drop_ena !== 1'b1 || err_count !== 16'd1) begin
      fails++; $display("FAIL oversize_drop: drop__ENA=%0b errCount=%0d, required 1 1", drop_ena, err_count);
    end
    for (int i = 0; i < 10; i++) put_word(32'hF000_0000 + 32'(i));
    tests++;
    if (out_ena !== 1'b0 || hs_cnt !== h0 || drop_cnt !== d0 + 1) begin
      fails++; $display("FAIL oversize_silent: out__ENA=%0b msgs=%0d drops=%0d, required 0 %0d %0d",
                        out_ena, hs_cnt, drop_cnt, h0, d0 + 1);
    end
    put_word(32'h0002_0002);
    put_word(32'h1234_5678);
    tests++;
    if (out_ena !== 1'b1 || out_method !== 16'd2 || out_length !== 4'd1 || out_data !== 256'h1234_5678) begin
      fails++; $display("FAIL oversize_next_msg: ena=%0b method=%0d length=%0d data=%h, required 1 2 1 12345678",
                        out_ena, out_method, out_length, out_data);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_zero_len();
    out_rdy = 1'b1;
    put_word(32'h0005_0000);
    tests++;
    if (drop_ena !== 1'b1 || err_count !== 16'd2) begin
      fails++; $display("FAIL zero_len_drop: drop__ENA=%0b errCount=%0d, required 1 2", drop_ena, err_count);
    end
    @(posedge CLK);
    #1;
    tests++;
    if (drop_ena !== 1'b0 || in_rdy !== 1'b1) begin
      fails++; $display("FAIL zero_len_pulse: drop__ENA=%0b in__RDY=%0b, required 0 1", drop_ena, in_rdy);
    end
    put_word(32'h0004_0001);
    tests++;
    if (out_ena !== 1'b1 || out_method !== 16'd4 || out_length !== 4'd0) begin
      fails++; $display("FAIL zero_len_next_hdr: ena=%0b method=%0d length=%0d, required 1 4 0",
                        out_ena, out_method, out_length);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_backpressure();
    int h0;
    int bad;
    out_rdy = 1'b0;
    h0 = hs_cnt;
    put_word(32'h0006_0002);
    put_word(32'hDEAD_0001);
    in_ena  = 1'b1;
    in_data = 32'h1111_1111;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      tests++;
      if (in_rdy !== 1'b0 || out_ena !== 1'b1 || out_method !== 16'd6 ||
          out_length !== 4'd1 || out_data !== 256'hDEAD_0001) begin
        fails++;
        $display("FAIL backpressure_hold: cycle %0d rdy=%0b ena=%0b method=%0d length=%0d data=%h, required 0 1 6 1 dead0001",
                 c, in_rdy, out_ena, out_method, out_length, out_data);
      end
    end
    tests++;
    if (hs_cnt !== h0) begin fails++; $display("FAIL backpressure_early: msgs=%0d, required %0d", hs_cnt, h0); end
    @(negedge CLK);
    out_rdy = 1'b1;
    @(posedge CLK);
    #1;
    in_ena = 1'b0;
    tests++;
    if (out_ena !== 1'b0 || hs_cnt !== h0 + 1 || err_count !== 16'd2) begin
      fails++; $display("FAIL backpressure_release: ena=%0b msgs=%0d err=%0d, required 0 %0d 2",
                        out_ena, hs_cnt, err_count, h0 + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int h0;
    out_rdy = 1'b1;
    h0 = hs_cnt;
    put_word(32'h0008_0006);
    put_word(32'h5555_0001);
    put_word(32'h5555_0002);
    put_word(32'h5555_0003);
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if (in_rdy !== 1'b0 || out_ena !== 1'b0 || err_count !== 16'd0) begin
      fails++; $display("FAIL midreset_state: rdy=%0b ena=%0b err=%0d, required 0 0 0", in_rdy, out_ena, err_count);
    end
    nRST = 1'b1;
    put_word(32'h0009_0002);
    tests++;
    if (out_ena !== 1'b0) begin fails++; $display("FAIL midreset_stale: out__ENA=%0b, required 0", out_ena); end
    put_word(32'hCAFE_F00D);
    tests++;
    if (out_ena !== 1'b1 || out_method !== 16'd9 || out_length !== 4'd1 || out_data !== 256'hCAFE_F00D) begin
      fails++; $display("FAIL midreset_msg: ena=%0b method=%0d length=%0d data=%h, required 1 9 1 cafef00d",
                        out_ena, out_method, out_length, out_data);
    end
    @(posedge CLK);
    #1;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (hs_cnt !== h0 + 1 || out_ena !== 1'b0) begin
      fails++; $display("FAIL midreset_count: msgs=%0d ena=%0b, required %0d 0", hs_cnt, out_ena, h0 + 1);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    hs_cnt   = 0;
    drop_cnt = 0;
    test_reset();
    test_basic();
    test_header_only();
    test_oversize();
    test_zero_len();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
